// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, defaults and the round-robin search used by the FIFO write
// arbiter and its picker.
package fifo_wr_arbiter_pkg;

  localparam int unsigned DEF_WIDTH     = 14;
  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_BURST_LEN = 4;

  // Upper bound on requesters; the search function works on this width.
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_sel_t;

  // First set bit of req, searching last+1, last+2, ... modulo num_req.
  function automatic rr_sel_t rr_next(input logic [MAX_REQ-1:0]   req,
                                      input logic [MAX_IDX_W-1:0] last,
                                      input int unsigned          num_req);
    rr_sel_t              sel;
    int unsigned          cand;
    logic [MAX_IDX_W-1:0] c;
    sel = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = (32'(last) + k) % num_req;
      c    = MAX_IDX_W'(cand);
      if ((k <= num_req) && !sel.found && req[c]) begin
        sel.found = 1'b1;
        sel.idx   = c;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req     : request vector
//   last    : index of the most recent winner (search starts at last+1)
//   valid_c : some request present
//   gnt_c   : one-hot winner (zero when no request)
//   idx_c   : winner index
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid_c,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c
);

  rr_sel_t sel;

  // Search is done at the package's maximum width and narrowed back.
  always_comb begin
    sel     = rr_next(MAX_REQ'(req), MAX_IDX_W'(last), NUM_REQ);
    valid_c = sel.found;
    idx_c   = IDX_W'(sel.idx);
    gnt_c   = sel.found ? (NUM_REQ'(1) << idx_c) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// Each grant is held for up to BURST_LEN words; one IDLE decision cycle
// separates bursts.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-requester request (word valid while high)
//   req_data   : packed words, requester i at [i*WIDTH +: WIDTH]
//   ack        : one-hot-or-zero, word of requester i taken this cycle
//   gnt        : registered one-hot-or-zero current owner
//   fifo_full  : FIFO full flag (backpressure)
//   fifo_wr_en : FIFO write enable
//   fifo_din   : FIFO write data
//   busy       : state is BURST
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_din,
  output logic                     busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic [WIDTH-1:0]   words [NUM_REQ];
  logic               own_req;
  logic               accept;
  logic               cnt_last;

  // Unpack requester words for a simple indexed mux.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req),
    .last    (last_q),
    .valid_c (pick_valid),
    .gnt_c   (pick_gnt),
    .idx_c   (pick_idx)
  );

  // While in BURST, last_q holds the owner's index.
  assign own_req  = req[last_q];
  assign cnt_last = (cnt_q == CNT_W'(BURST_LEN - 1));

  assign gnt  = gnt_q;
  assign busy = (state_q == BURST);

  // State register; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and zero-latency write-side outputs.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    ack        = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = words[last_q];

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BURST;
          gnt_d   = pick_gnt;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        // Never write while full; full with req held simply stalls.
        accept     = own_req & ~fifo_full;
        fifo_wr_en = accept;
        ack        = accept ? gnt_q : '0;
        if (!own_req) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (accept) begin
          if (cnt_last) begin
            state_d = IDLE;
            gnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle-level behavioural model plus directed
// scenarios with hand-computed expectations.
module tb_fifo_wr_arbiter;

  localparam int W  = 14;
  localparam int N  = 4;
  localparam int BL = 4;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     ack;
  logic [N-1:0]     gnt;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_din;
  logic             busy;

  fifo_wr_arbiter #(
    .WIDTH     (W),
    .NUM_REQ   (N),
    .BURST_LEN (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester data: requester i presents i*1000 + number of words it has had taken.
  int           seq [N];
  logic [N-1:0] ack_seen;

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(i * 1000 + seq[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (ack_seen[i]) seq[i]++;
    drive_data();
  endtask

  // Behavioural model: owner (-1 none), words taken this burst, last winner.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_last  = N - 1;

  int            wr_pulses  = 0;
  int            ack_pulses = 0;
  int            full_viol  = 0;
  int            multi_hot  = 0;
  logic          wr_log [$];
  logic [W-1:0]  din_log [$];
  int            gnt_log [$];
  logic [N-1:0]  prev_gnt = '0;

  always @(negedge clk) begin
    logic [N-1:0] e_ack, e_gnt;
    logic         e_wr, e_busy, take, found;
    int           c;
    ack_seen = ack;
    if (fifo_wr_en === 1'b1) begin
      wr_pulses++;
      din_log.push_back(fifo_din);
    end
    ack_pulses += $countones(ack);
    if (fifo_wr_en === 1'b1 && fifo_full) full_viol++;
    if ($countones(ack) > 1) multi_hot++;
    wr_log.push_back(fifo_wr_en);
    if (gnt != '0 && gnt != prev_gnt)
      for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
    prev_gnt = gnt;

    if (rst) begin
      m_owner = -1;
      m_cnt   = 0;
      m_last  = N - 1;
      chk("rst_outputs", 64'({ack, gnt, fifo_wr_en, busy}), 64'(0));
    end else begin
      e_ack = '0; e_gnt = '0; e_wr = 1'b0; e_busy = 1'b0; take = 1'b0;
      if (m_owner >= 0) begin
        e_busy = 1'b1;
        e_gnt  = N'(1) << m_owner;
        take   = req[2'(m_owner)] && !fifo_full;
        e_wr   = take;
        if (take) e_ack = N'(1) << m_owner;
      end
      chk("model_ack",   64'(ack),        64'(e_ack));
      chk("model_wr_en", 64'(fifo_wr_en), 64'(e_wr));
      chk("model_gnt",   64'(gnt),        64'(e_gnt));
      chk("model_busy",  64'(busy),       64'(e_busy));
      if (e_wr) chk("model_din", 64'(fifo_din), 64'(req_data[m_owner*W +: W]));

      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && req[2'(c)]) begin
            found   = 1'b1;
            m_owner = c;
            m_last  = c;
            m_cnt   = 0;
          end
        end
      end else if (!req[2'(m_owner)]) begin
        m_owner = -1;
      end else if (take) begin
        m_cnt++;
        if (m_cnt == BL) m_owner = -1;
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int           w0;
  int           s0;
  logic [9:0]   pat;
  int           rr_exp [5];

  initial begin
    rst       = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    drive_data();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt",  64'(gnt),        64'(0));
    chk("reset_busy", 64'(busy),       64'(0));
    chk("reset_ack",  64'(ack),        64'(0));
    chk("reset_wr",   64'(fifo_wr_en), 64'(0));

    // Single requester: 4 writes, bubble, 4 writes; words in order.
    do_reset();
    wr_log.delete();
    din_log.delete();
    s0  = seq[2];
    req = 4'b0100;
    tick();
    tick();
    chk("single_gnt", 64'(gnt), 64'(4'b0100));
    repeat (8) tick();
    pat = '0;
    for (int k = 0; k < 10 && k < wr_log.size(); k++) pat[9-k] = wr_log[k];
    chk("single_pattern", 64'(pat), 64'(10'b0111101111));
    chk("single_count", 64'(din_log.size()), 64'(8));
    if (din_log.size() == 8)
      for (int k = 0; k < 8; k++) chk("single_word", 64'(din_log[k]), 64'(W'(2000 + s0 + k)));
    req = '0;

    // Round-robin with all requesting: 0,1,2,3,0 and 20 words in 25 cycles.
    do_reset();
    gnt_log.delete();
    w0  = wr_pulses;
    req = 4'b1111;
    repeat (25) tick();
    chk("rr_words", 64'(wr_pulses - w0), 64'(20));
    chk("rr_grants", 64'(gnt_log.size()), 64'(5));
    rr_exp = '{0, 1, 2, 3, 0};
    if (gnt_log.size() == 5)
      for (int k = 0; k < 5; k++) chk("rr_order", 64'(gnt_log[k]), 64'(rr_exp[k]));
    req = '0;

    // Backpressure: owner 1 stalls at 2 words for 3 cycles, then finishes.
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0011;
    tick();
    tick();
    fifo_full = 1'b1;
    w0 = wr_pulses;
    repeat (3) tick();
    chk("bp_stalled", 64'(wr_pulses - w0), 64'(0));
    chk("bp_gnt_hold", 64'(gnt), 64'(4'b0010));
    fifo_full = 1'b0;
    w0 = wr_pulses;
    tick();
    tick();
    chk("bp_remaining", 64'(wr_pulses - w0), 64'(2));
    chk("bp_idle", 64'(busy), 64'(0));
    tick();
    chk("bp_rotate", 64'(gnt), 64'(4'b0001));
    req = '0;

    // Early drop: owner 3 leaves after one word, grant wraps to 0.
    do_reset();
    req = 4'b1000;
    tick();
    chk("drop_gnt3", 64'(gnt), 64'(4'b1000));
    tick();
    req = 4'b0001;
    w0  = wr_pulses;
    tick();
    chk("drop_no_write", 64'(wr_pulses - w0), 64'(0));
    chk("drop_idle_gnt", 64'(gnt), 64'(0));
    chk("drop_idle_busy", 64'(busy), 64'(0));
    tick();
    chk("drop_wrap", 64'(gnt), 64'(4'b0001));
    req = '0;

    // Reset in the middle of a burst drops outputs immediately.
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    tick();
    chk("mid_pre_wr", 64'(fifo_wr_en), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", 64'(ack),        64'(0));
    chk("mid_rst_wr",  64'(fifo_wr_en), 64'(0));
    chk("mid_rst_gnt", 64'(gnt),        64'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("mid_first_gnt", 64'(gnt), 64'(4'b0001));
    req = '0;
    tick();

    chk("sb_wr_vs_ack", 64'(wr_pulses), 64'(ack_pulses));
    chk("sb_full_write", 64'(full_viol), 64'(0));
    chk("sb_multi_hot",  64'(multi_hot), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
